// File: rtl/int_ctrl_pkg.sv
// rtl/int_ctrl_pkg.sv - register offsets, limits and FSM encoding for int_ctrl
package int_ctrl_pkg;

  // Register offsets relative to BASE_ADDR
  localparam logic [15:0] OFF_STATUS  = 16'd0;
  localparam logic [15:0] OFF_MASK    = 16'd1;
  localparam logic [15:0] OFF_EDGE    = 16'd2;
  localparam logic [15:0] OFF_CFG     = 16'd3;
  localparam logic [15:0] OFF_RAW     = 16'd4;
  localparam logic [15:0] OFF_COUNT   = 16'd5;
  localparam logic [15:0] WINDOW_SIZE = 16'd6;

  localparam logic [15:0] COUNT_MAX   = 16'hFFFF;

  // Pulse-mode output sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } intState_t;

endpackage

// File: rtl/int_evt_sync.sv
// rtl/int_evt_sync.sv - single-bit event synchronizer with rising-edge detect
//  clk_i     in   system clock (sysClk)
//  reset_i   in   synchronous active-high reset
//  evtAsync  in   asynchronous event input
//  evtLevel  out  synchronized level (second sync flop)
//  evtRise   out  one-cycle pulse on a synchronized 0->1 transition
module int_evt_sync (
  input  logic clk_i,
  input  logic reset_i,
  input  logic evtAsync,
  output logic evtLevel,
  output logic evtRise
);

  logic syncA;
  logic syncB;
  logic prevB;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      syncA <= 1'b0;
      syncB <= 1'b0;
      prevB <= 1'b0;
    end else begin
      syncA <= evtAsync;
      syncB <= syncA;
      prevB <= syncB;
    end
  end

  assign evtLevel = syncB;
  assign evtRise  = syncB & ~prevB;

endmodule

// File: rtl/int_ctrl.sv
// rtl/int_ctrl.sv - interrupt controller: W1C status, mask, level/pulse host interrupt
//  clk_i           in   system clock (sysClk)
//  reset_i         in   synchronous active-high reset
//  set_wr_en/addr/data   register write strobe, address, data
//  set_rd_en/addr        register read strobe, address
//  set_rd_data     out  registered read data, held until next read strobe
//  set_rd_data_en  out  1 while set_rd_data belongs to this block
//  evt_i           in   asynchronous event inputs
//  fpga_int_out    out  interrupt to host (polarity from INT_ACT_HI)
//  t_out           out  debug, 1 while the pulse FSM is not idle
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int          N_EVT      = 8,
  parameter logic [15:0] BASE_ADDR  = 16'h0100,
  parameter bit          INT_ACT_HI = 1'b1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             set_wr_en,
  input  logic [15:0]      set_wr_addr,
  input  logic [15:0]      set_wr_data,
  input  logic             set_rd_en,
  input  logic [15:0]      set_rd_addr,
  output logic [15:0]      set_rd_data,
  output logic             set_rd_data_en,
  input  logic [N_EVT-1:0] evt_i,
  output logic             fpga_int_out,
  output logic             t_out
);

  logic [N_EVT-1:0] evtLevel;
  logic [N_EVT-1:0] evtRise;

  for (genvar g = 0; g < N_EVT; g++) begin : gEvtSync
    int_evt_sync uSync (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .evtAsync (evt_i[g]),
      .evtLevel (evtLevel[g]),
      .evtRise  (evtRise[g])
    );
  end

  logic [N_EVT-1:0] statusReg;
  logic [N_EVT-1:0] maskReg;
  logic [N_EVT-1:0] edgeReg;
  logic             cfgEn;
  logic             cfgMode;
  logic [7:0]       pulseLen;
  logic [15:0]      countReg;
  logic [15:0]      rdDataReg;
  logic             rdDataEnReg;
  logic             levelInt;

  intState_t        state;
  intState_t        nextState;
  logic [7:0]       cnt;
  logic [7:0]       nextCnt;
  logic             retrig;
  logic             nextRetrig;

  // Address decode (offset subtraction wraps, so addresses below the base fall outside)
  logic [15:0] wrOff;
  logic [15:0] rdOff;
  logic        wrStatus, wrMask, wrEdge, wrCfg, wrCount;
  logic        rdHit;

  assign wrOff    = set_wr_addr - BASE_ADDR;
  assign rdOff    = set_rd_addr - BASE_ADDR;
  assign wrStatus = set_wr_en && (wrOff == OFF_STATUS);
  assign wrMask   = set_wr_en && (wrOff == OFF_MASK);
  assign wrEdge   = set_wr_en && (wrOff == OFF_EDGE);
  assign wrCfg    = set_wr_en && (wrOff == OFF_CFG);
  assign wrCount  = set_wr_en && (wrOff == OFF_COUNT);
  assign rdHit    = rdOff < WINDOW_SIZE;

  logic [N_EVT-1:0] w1c;
  logic [N_EVT-1:0] setV;
  logic             pend;
  logic             newPend;
  logic             cfgKill;
  logic [7:0]       loadLen;

  assign w1c     = wrStatus ? set_wr_data[N_EVT-1:0] : '0;
  assign setV    = (edgeReg & evtRise) | (~edgeReg & evtLevel);
  assign pend    = (|(statusReg & maskReg)) & cfgEn;
  assign newPend = (|(setV & maskReg)) & cfgEn;
  // A CFG write that changes mode or drops enable aborts any pulse in flight
  assign cfgKill = wrCfg && ((set_wr_data[1] != cfgMode) || !set_wr_data[0]);
  assign loadLen = (pulseLen == 8'd0) ? 8'd0 : pulseLen - 8'd1;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      statusReg <= '0;
      maskReg   <= '0;
      edgeReg   <= '0;
      cfgEn     <= 1'b0;
      cfgMode   <= 1'b0;
      pulseLen  <= 8'd0;
      countReg  <= 16'd0;
      levelInt  <= 1'b0;
    end else begin
      // New set is OR'd after the clear so it wins over W1C on the same bit
      statusReg <= (statusReg & ~w1c) | setV;
      if (wrMask) maskReg <= set_wr_data[N_EVT-1:0];
      if (wrEdge) edgeReg <= set_wr_data[N_EVT-1:0];
      if (wrCfg) begin
        cfgEn    <= set_wr_data[0];
        cfgMode  <= set_wr_data[1];
        pulseLen <= set_wr_data[15:8];
      end
      if (wrCount) begin
        countReg <= 16'd0;
      end else if (newPend && (countReg != COUNT_MAX)) begin
        countReg <= countReg + 16'd1;
      end
      levelInt <= pend & ~cfgKill;
    end
  end

  // Read path: sampled before this cycle's write takes effect
  logic [15:0] rdValue;

  always_comb begin
    rdValue = 16'd0;
    case (rdOff)
      OFF_STATUS: rdValue = 16'(statusReg);
      OFF_MASK:   rdValue = 16'(maskReg);
      OFF_EDGE:   rdValue = 16'(edgeReg);
      OFF_CFG:    rdValue = {pulseLen, 6'd0, cfgMode, cfgEn};
      OFF_RAW:    rdValue = 16'(evtLevel);
      OFF_COUNT:  rdValue = countReg;
      default:    rdValue = 16'd0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rdDataReg   <= 16'd0;
      rdDataEnReg <= 1'b0;
    end else if (set_rd_en) begin
      rdDataReg   <= rdHit ? rdValue : 16'd0;
      rdDataEnReg <= rdHit;
    end
  end

  assign set_rd_data    = rdDataReg;
  assign set_rd_data_en = rdDataEnReg;

  // Pulse-mode FSM
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state  <= ST_IDLE;
      cnt    <= 8'd0;
      retrig <= 1'b0;
    end else begin
      state  <= nextState;
      cnt    <= nextCnt;
      retrig <= nextRetrig;
    end
  end

  always_comb begin
    nextState  = state;
    nextCnt    = cnt;
    nextRetrig = retrig;
    case (state)
      ST_IDLE: begin
        if (newPend) begin
          nextState = ST_PULSE;
          nextCnt   = loadLen;
        end
      end
      ST_PULSE: begin
        if (newPend) nextRetrig = 1'b1;
        if (cnt == 8'd0) nextState = ST_GAP;
        else             nextCnt   = cnt - 8'd1;
      end
      ST_GAP: begin
        if (retrig || newPend) begin
          nextState  = ST_PULSE;
          nextRetrig = 1'b0;
          nextCnt    = loadLen;
        end else begin
          nextState = ST_IDLE;
        end
      end
      default: nextState = ST_IDLE;
    endcase
    // Level mode keeps the FSM parked
    if (!cfgMode || cfgKill) begin
      nextState  = ST_IDLE;
      nextRetrig = 1'b0;
      nextCnt    = 8'd0;
    end
  end

  logic intActive;

  assign intActive    = cfgMode ? (state == ST_PULSE) : levelInt;
  assign fpga_int_out = INT_ACT_HI ? intActive : ~intActive;
  assign t_out        = (state != ST_IDLE);

endmodule

// File: tb/tb_int_ctrl.sv
// tb/tb_int_ctrl.sv - directed self-checking bench for int_ctrl
module tb_int_ctrl;

  localparam logic [15:0] BASE = 16'h0100;

  logic        sysClk = 1'b0;
  logic        reset_i;
  logic        set_wr_en;
  logic [15:0] set_wr_addr;
  logic [15:0] set_wr_data;
  logic        set_rd_en;
  logic [15:0] set_rd_addr;
  logic [15:0] set_rd_data;
  logic        set_rd_data_en;
  logic [7:0]  evt;
  logic        fpga_int_out;
  logic        t_out;

  int vecCount  = 0;
  int missCount = 0;

  int_ctrl #(
    .N_EVT      (8),
    .BASE_ADDR  (BASE),
    .INT_ACT_HI (1'b1)
  ) dut (
    .clk_i          (sysClk),
    .reset_i        (reset_i),
    .set_wr_en      (set_wr_en),
    .set_wr_addr    (set_wr_addr),
    .set_wr_data    (set_wr_data),
    .set_rd_en      (set_rd_en),
    .set_rd_addr    (set_rd_addr),
    .set_rd_data    (set_rd_data),
    .set_rd_data_en (set_rd_data_en),
    .evt_i          (evt),
    .fpga_int_out   (fpga_int_out),
    .t_out          (t_out)
  );

  always #5 sysClk = ~sysClk;

  task automatic tick();
    @(posedge sysClk);
    #1;
  endtask

  task automatic wrReg(input logic [15:0] off, input logic [15:0] data);
    set_wr_en   = 1'b1;
    set_wr_addr = BASE + off;
    set_wr_data = data;
    tick();
    set_wr_en   = 1'b0;
  endtask

  task automatic rdReg(input logic [15:0] addr, output logic [15:0] d, output logic en);
    set_rd_en   = 1'b1;
    set_rd_addr = addr;
    tick();
    set_rd_en   = 1'b0;
    d  = set_rd_data;
    en = set_rd_data_en;
  endtask

  task automatic test_reset();
    logic [15:0] d;
    logic        en;
    reset_i = 1'b1;
    tick();
    tick();
    vecCount++;
    if ({fpga_int_out, t_out, set_rd_data_en, set_rd_data} !== 19'd0) begin
      missCount++;
      $display("FAIL reset_outputs: got int=%b t=%b en=%b data=%h expected all 0",
               fpga_int_out, t_out, set_rd_data_en, set_rd_data);
    end
    reset_i = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) begin
      rdReg(BASE + 16'(i), d, en);
      vecCount++;
      if (d !== 16'h0000 || en !== 1'b1) begin
        missCount++;
        $display("FAIL reset_read_%0d: got data=%h en=%b expected data=0000 en=1", i, d, en);
      end
    end
    tick();
    vecCount++;
    if (set_rd_data_en !== 1'b1) begin
      missCount++;
      $display("FAIL read_en_held: got %b expected 1", set_rd_data_en);
    end
    rdReg(16'h0000, d, en);
    vecCount++;
    if (d !== 16'h0000 || en !== 1'b0) begin
      missCount++;
      $display("FAIL read_outside_low: got data=%h en=%b expected data=0000 en=0", d, en);
    end
    rdReg(BASE + 16'd6, d, en);
    vecCount++;
    if (en !== 1'b0) begin
      missCount++;
      $display("FAIL read_outside_high: got en=%b expected 0", en);
    end
  endtask

  task automatic test_level_mode();
    logic [15:0] d;
    logic        en;
    wrReg(16'd1, 16'h0001);
    wrReg(16'd2, 16'h0001);
    wrReg(16'd3, 16'h0001);
    evt[0] = 1'b1;
    tick(); tick(); tick();
    vecCount++;
    if (fpga_int_out !== 1'b0) begin
      missCount++;
      $display("FAIL level_int_early: got %b expected 0", fpga_int_out);
    end
    tick();
    vecCount++;
    if (fpga_int_out !== 1'b1) begin
      missCount++;
      $display("FAIL level_int_assert: got %b expected 1", fpga_int_out);
    end
    evt[0] = 1'b0;
    rdReg(BASE + 16'd0, d, en);
    vecCount++;
    if (d !== 16'h0001) begin
      missCount++;
      $display("FAIL level_status: got %h expected 0001", d);
    end
    wrReg(16'd0, 16'h0001);
    tick();
    vecCount++;
    if (fpga_int_out !== 1'b0) begin
      missCount++;
      $display("FAIL level_w1c_int: got %b expected 0", fpga_int_out);
    end
    rdReg(BASE + 16'd0, d, en);
    vecCount++;
    if (d !== 16'h0000) begin
      missCount++;
      $display("FAIL level_w1c_status: got %h expected 0000", d);
    end
    rdReg(BASE + 16'd5, d, en);
    vecCount++;
    if (d !== 16'h0001) begin
      missCount++;
      $display("FAIL level_count: got %h expected 0001", d);
    end
  endtask

  task automatic test_pulse_single();
    logic [15:0] d;
    logic        en;
    logic [11:0] intPat;
    logic [11:0] tPat;
    wrReg(16'd3, 16'h0303);
    wrReg(16'd5, 16'h0000);
    for (int i = 0; i < 12; i++) begin
      if (i == 0) evt[0] = 1'b1;
      tick();
      intPat[i] = fpga_int_out;
      tPat[i]   = t_out;
    end
    vecCount++;
    if (intPat !== 12'b0000_0001_1100) begin
      missCount++;
      $display("FAIL pulse_single_int: got %b expected 000000011100", intPat);
    end
    vecCount++;
    if (tPat !== 12'b0000_0011_1100) begin
      missCount++;
      $display("FAIL pulse_single_tout: got %b expected 000000111100", tPat);
    end
    rdReg(BASE + 16'd5, d, en);
    vecCount++;
    if (d !== 16'h0001) begin
      missCount++;
      $display("FAIL pulse_single_count: got %h expected 0001", d);
    end
    evt[0] = 1'b0;
    tick(); tick(); tick(); tick();
    wrReg(16'd0, 16'h00FF);
  endtask

  task automatic test_back_to_back();
    logic [15:0] d;
    logic        en;
    logic [15:0] intPat;
    wrReg(16'd1, 16'h0003);
    wrReg(16'd2, 16'h0003);
    wrReg(16'd5, 16'h0000);
    for (int i = 0; i < 16; i++) begin
      if (i == 0) evt[0] = 1'b1;
      if (i == 2) evt[1] = 1'b1;
      tick();
      intPat[i] = fpga_int_out;
    end
    vecCount++;
    if (intPat !== 16'h01DC) begin
      missCount++;
      $display("FAIL retrig_pattern: got %b expected 0000000111011100", intPat);
    end
    rdReg(BASE + 16'd5, d, en);
    vecCount++;
    if (d !== 16'h0002) begin
      missCount++;
      $display("FAIL retrig_count: got %h expected 0002", d);
    end
    rdReg(BASE + 16'd0, d, en);
    vecCount++;
    if (d !== 16'h0003) begin
      missCount++;
      $display("FAIL retrig_status: got %h expected 0003", d);
    end
    evt = 8'h00;
    tick(); tick(); tick(); tick();
    wrReg(16'd0, 16'h00FF);
  endtask

  task automatic test_w1c_race();
    logic [15:0] d;
    logic        en;
    wrReg(16'd3, 16'h0001);
    wrReg(16'd1, 16'h0001);
    wrReg(16'd2, 16'h0005);
    evt[0] = 1'b1;
    tick(); tick();
    // The rise lands in STATUS on the same edge as this W1C
    wrReg(16'd0, 16'h0001);
    rdReg(BASE + 16'd0, d, en);
    vecCount++;
    if (d !== 16'h0001) begin
      missCount++;
      $display("FAIL w1c_race_status: got %h expected 0001", d);
    end
    wrReg(16'd0, 16'h0001);
    tick();
    evt[2] = 1'b1;
    tick(); tick(); tick(); tick();
    rdReg(BASE + 16'd0, d, en);
    vecCount++;
    if (d !== 16'h0004) begin
      missCount++;
      $display("FAIL unmasked_status: got %h expected 0004", d);
    end
    vecCount++;
    if (fpga_int_out !== 1'b0) begin
      missCount++;
      $display("FAIL unmasked_int: got %b expected 0", fpga_int_out);
    end
  endtask

  task automatic test_count_and_reset();
    logic [15:0] d;
    logic        en;
    evt = 8'h01;
    wrReg(16'd2, 16'h0000);
    wrReg(16'd5, 16'h0000);
    repeat (70000) tick();
    rdReg(BASE + 16'd5, d, en);
    vecCount++;
    if (d !== 16'hFFFF) begin
      missCount++;
      $display("FAIL count_saturate: got %h expected ffff", d);
    end
    // Event still high: the clear must beat the increment on the write edge
    wrReg(16'd5, 16'h1234);
    rdReg(BASE + 16'd5, d, en);
    vecCount++;
    if (d !== 16'h0000) begin
      missCount++;
      $display("FAIL count_clear: got %h expected 0000", d);
    end
    wrReg(16'd3, 16'h0303);
    tick();
    vecCount++;
    if (fpga_int_out !== 1'b1) begin
      missCount++;
      $display("FAIL pulse_before_reset: got %b expected 1", fpga_int_out);
    end
    reset_i = 1'b1;
    tick();
    vecCount++;
    if (fpga_int_out !== 1'b0 || t_out !== 1'b0 || set_rd_data_en !== 1'b0) begin
      missCount++;
      $display("FAIL reset_mid_pulse: got int=%b t=%b en=%b expected 0 0 0",
               fpga_int_out, t_out, set_rd_data_en);
    end
    reset_i = 1'b0;
    evt = 8'h00;
    tick();
  endtask

  initial begin
    reset_i     = 1'b1;
    set_wr_en   = 1'b0;
    set_wr_addr = 16'h0000;
    set_wr_data = 16'h0000;
    set_rd_en   = 1'b0;
    set_rd_addr = 16'h0000;
    evt         = 8'h00;
    test_reset();
    test_level_mode();
    test_pulse_single();
    test_back_to_back();
    test_w1c_race();
    test_count_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
